// File: rtl/tictactoe_pkg.sv
// Shared types and helpers for the TicTacToe game controller:
// cell codes, FSM states and the 9-cell board type.
package tictactoe_pkg;

    localparam logic [1:0] CELDA_VACIA = 2'b00;
    localparam logic [1:0] JUGADOR1    = 2'b01;
    localparam logic [1:0] JUGADOR2    = 2'b10;

    typedef enum logic [1:0] {INICIO, ESPERA, VERIFICA, FIN} estado_t;

    typedef logic [8:0][1:0] tablero_t;

    function automatic logic [1:0] codigo_jugador(input logic turno);
        return turno ? JUGADOR2 : JUGADOR1;
    endfunction

    function automatic logic tablero_lleno(input tablero_t tablero);
        logic lleno;
        lleno = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (tablero[i] == CELDA_VACIA) lleno = 1'b0;
        end
        return lleno;
    endfunction

endpackage

// File: rtl/control_juego_ganador.sv
// Combinational win checker: high when any row, column or diagonal
// holds three identical non-empty marks.
module always_ganador
    import tictactoe_pkg::*;
(
    input  logic [8:0][1:0] i_tablero,
    output logic            o_hay_ganador
);

    function automatic logic linea(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        return (a != CELDA_VACIA) && (a == b) && (b == c);
    endfunction

    assign o_hay_ganador = linea(i_tablero[0], i_tablero[1], i_tablero[2]) ||
                           linea(i_tablero[3], i_tablero[4], i_tablero[5]) ||
                           linea(i_tablero[6], i_tablero[7], i_tablero[8]) ||
                           linea(i_tablero[0], i_tablero[3], i_tablero[6]) ||
                           linea(i_tablero[1], i_tablero[4], i_tablero[7]) ||
                           linea(i_tablero[2], i_tablero[5], i_tablero[8]) ||
                           linea(i_tablero[0], i_tablero[4], i_tablero[8]) ||
                           linea(i_tablero[2], i_tablero[4], i_tablero[6]);

endmodule

// File: rtl/control_juego.sv
// TicTacToe sequencing controller: owns the board, alternates turns,
// validates moves and reports win, draw and turn timeout.
module control_juego
    import tictactoe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            mov_valido,
    input  logic [3:0]      posicion,
    input  logic            reiniciar,
    output logic [8:0][1:0] matrizDeJuego,
    output logic            turno,
    output logic [1:0]      ganador,
    output logic            empate,
    output logic            mov_error,
    output logic            timeout,
    output logic            juego_activo
);

    localparam int            TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    estado_t       r_estado;
    logic [TW-1:0] r_timer;
    logic          w_hay_ganador;
    logic          w_celda_libre;
    logic          w_mov_legal;
    logic          w_expira;

    always_ganador u_ganador (
        .i_tablero     (matrizDeJuego),
        .o_hay_ganador (w_hay_ganador)
    );

    // Decoded lookup so out-of-range positions never index the board.
    always_comb begin
        w_celda_libre = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (posicion == 4'(i)) w_celda_libre = (matrizDeJuego[i] == CELDA_VACIA);
        end
    end

    assign w_mov_legal = mov_valido && (posicion <= 4'd8) && w_celda_libre;
    assign w_expira    = (r_timer == TMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado      <= INICIO;
            r_timer       <= '0;
            matrizDeJuego <= '0;
            turno         <= 1'b0;
            ganador       <= CELDA_VACIA;
            empate        <= 1'b0;
            mov_error     <= 1'b0;
            timeout       <= 1'b0;
            juego_activo  <= 1'b0;
        end else begin
            mov_error <= 1'b0;
            timeout   <= 1'b0;
            case (r_estado)
                INICIO: begin
                    matrizDeJuego <= '0;
                    turno         <= 1'b0;
                    r_timer       <= '0;
                    ganador       <= CELDA_VACIA;
                    empate        <= 1'b0;
                    juego_activo  <= 1'b1;
                    r_estado      <= ESPERA;
                end
                ESPERA: begin
                    if (w_mov_legal) begin
                        for (int i = 0; i < 9; i++) begin
                            if (posicion == 4'(i)) matrizDeJuego[i] <= codigo_jugador(turno);
                        end
                        r_timer  <= '0;
                        r_estado <= VERIFICA;
                    end else begin
                        if (mov_valido) mov_error <= 1'b1;
                        // A rejected move freezes the timer unless the turn is expiring.
                        if (w_expira) begin
                            turno   <= ~turno;
                            r_timer <= '0;
                            timeout <= 1'b1;
                        end else if (!mov_valido) begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                VERIFICA: begin
                    if (w_hay_ganador) begin
                        ganador      <= codigo_jugador(turno);
                        juego_activo <= 1'b0;
                        r_estado     <= FIN;
                    end else if (tablero_lleno(matrizDeJuego)) begin
                        empate       <= 1'b1;
                        juego_activo <= 1'b0;
                        r_estado     <= FIN;
                    end else begin
                        turno    <= ~turno;
                        r_timer  <= '0;
                        r_estado <= ESPERA;
                    end
                end
                FIN: begin
                    if (reiniciar) r_estado <= INICIO;
                end
                default: r_estado <= INICIO;
            endcase
        end
    end

endmodule

// File: tb/tb_control_juego.sv
// Bench for control_juego: behavioural game model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_control_juego;

    localparam int T = 8;
    localparam int P_START = 0;
    localparam int P_WAIT  = 1;
    localparam int P_CHECK = 2;
    localparam int P_OVER  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mov_valido = 1'b0;
    logic [3:0]      posicion = 4'd0;
    logic            reiniciar = 1'b0;
    logic [8:0][1:0] matriz;
    logic            turno;
    logic [1:0]      ganador;
    logic            empate;
    logic            mov_error;
    logic            timeout;
    logic            juego_activo;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Behavioural model state
    int m_cell [9] = '{default: 0};
    int m_turn  = 0;
    int m_win   = 0;
    int m_draw  = 0;
    int m_err   = 0;
    int m_to    = 0;
    int m_phase = P_START;
    int m_idle  = 0;
    bit m_ok;

    always #5 clk = ~clk;

    control_juego #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .mov_valido    (mov_valido),
        .posicion      (posicion),
        .reiniciar     (reiniciar),
        .matrizDeJuego (matriz),
        .turno         (turno),
        .ganador       (ganador),
        .empate        (empate),
        .mov_error     (mov_error),
        .timeout       (timeout),
        .juego_activo  (juego_activo)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit model_win();
        int L [8][3];
        L = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        for (int k = 0; k < 8; k++) begin
            if (m_cell[L[k][0]] != 0 && m_cell[L[k][0]] == m_cell[L[k][1]] &&
                m_cell[L[k][1]] == m_cell[L[k][2]]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_full();
        int n = 0;
        for (int i = 0; i < 9; i++) if (m_cell[i] != 0) n++;
        return n == 9;
    endfunction

    function automatic int model_board();
        int v = 0;
        for (int i = 0; i < 9; i++) v |= m_cell[i] << (2 * i);
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) m_cell[i] = 0;
            m_turn = 0; m_win = 0; m_draw = 0; m_err = 0; m_to = 0; m_idle = 0;
            m_phase = P_START;
        end else begin
            m_err = 0;
            m_to  = 0;
            case (m_phase)
                P_START: begin
                    for (int i = 0; i < 9; i++) m_cell[i] = 0;
                    m_turn = 0; m_win = 0; m_draw = 0; m_idle = 0;
                    m_phase = P_WAIT;
                end
                P_WAIT: begin
                    m_ok = mov_valido && (posicion <= 4'd8);
                    if (m_ok) m_ok = (m_cell[posicion] == 0);
                    if (m_ok) begin
                        m_cell[posicion] = m_turn + 1;
                        m_idle  = 0;
                        m_phase = P_CHECK;
                    end else begin
                        if (mov_valido) m_err = 1;
                        if (m_idle == T - 1) begin
                            m_turn = 1 - m_turn;
                            m_idle = 0;
                            m_to   = 1;
                        end else if (!mov_valido) begin
                            m_idle++;
                        end
                    end
                end
                P_CHECK: begin
                    if (model_win()) begin
                        m_win = m_turn + 1;
                        m_phase = P_OVER;
                    end else if (model_full()) begin
                        m_draw = 1;
                        m_phase = P_OVER;
                    end else begin
                        m_turn = 1 - m_turn;
                        m_idle = 0;
                        m_phase = P_WAIT;
                    end
                end
                default: begin
                    if (reiniciar) m_phase = P_START;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("board",        int'(matriz),       model_board());
            check("turno",        int'(turno),        m_turn);
            check("ganador",      int'(ganador),      m_win);
            check("empate",       int'(empate),       m_draw);
            check("mov_error",    int'(mov_error),    m_err);
            check("timeout",      int'(timeout),      m_to);
            check("juego_activo", int'(juego_activo),
                  (m_phase == P_WAIT || m_phase == P_CHECK) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_move(input int p);
        mov_valido = 1'b1;
        posicion   = 4'(p);
        tick();
        mov_valido = 1'b0;
        tick();
    endtask

    initial begin
        int draw_seq [9];
        draw_seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

        tick();
        chk_en = 1;
        check("rst_board", int'(matriz), 0);
        check("rst_turno", int'(turno), 0);
        check("rst_activo", int'(juego_activo), 0);
        tick();
        rst = 1'b0;
        tick();

        // Row win by player 1
        do_move(0); do_move(3); do_move(1); do_move(4); do_move(2);
        check("row_ganador", int'(ganador), 1);
        check("row_board", int'(matriz), 18'b00_00_00_00_10_10_01_01_01);
        check("row_activo", int'(juego_activo), 0);

        // Moves in FIN are silently ignored
        mov_valido = 1'b1; posicion = 4'd5;
        tick();
        mov_valido = 1'b0;
        check("fin_no_error", int'(mov_error), 0);
        check("fin_frozen", int'(matriz[5]), 0);

        reiniciar = 1'b1;
        tick();
        reiniciar = 1'b0;
        tick();
        check("restart_board", int'(matriz), 0);
        check("restart_turno", int'(turno), 0);
        check("restart_activo", int'(juego_activo), 1);

        // Illegal moves: occupied cell, then out-of-range position
        do_move(0);
        mov_valido = 1'b1; posicion = 4'd0;
        tick();
        mov_valido = 1'b0;
        check("occupied_err", int'(mov_error), 1);
        check("occupied_turno", int'(turno), 1);
        tick();
        check("err_one_pulse", int'(mov_error), 0);
        mov_valido = 1'b1; posicion = 4'd9;
        tick();
        mov_valido = 1'b0;
        check("pos9_err", int'(mov_error), 1);
        check("pos9_board", int'(matriz), 1);

        reiniciar = 1'b1;
        tick();
        reiniciar = 1'b0;
        check("reiniciar_espera", int'(matriz), 1);

        // Reset while in VERIFICA
        mov_valido = 1'b1; posicion = 4'd4;
        tick();
        mov_valido = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstv_board", int'(matriz), 0);
        check("rstv_turno", int'(turno), 0);
        check("rstv_activo", int'(juego_activo), 0);
        tick();

        // Full board with no line
        foreach (draw_seq[i]) do_move(draw_seq[i]);
        check("draw_empate", int'(empate), 1);
        check("draw_ganador", int'(ganador), 0);

        // Turn expiry after T idle cycles in ESPERA
        reiniciar = 1'b1;
        tick();
        reiniciar = 1'b0;
        tick();
        repeat (7) tick();
        check("to_early", int'(timeout), 0);
        tick();
        check("to_pulse", int'(timeout), 1);
        check("to_turno", int'(turno), 1);
        tick();
        check("to_one_pulse", int'(timeout), 0);
        repeat (6) tick();
        mov_valido = 1'b1; posicion = 4'd4;
        tick();
        mov_valido = 1'b0;
        check("expiry_move_no_to", int'(timeout), 0);
        check("expiry_move_cell", int'(matriz[4]), 2);
        tick();

        // Randomised play
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rst        = ($urandom % 100) == 0;
            mov_valido = ($urandom % 3) == 0;
            posicion   = 4'($urandom % 11);
            reiniciar  = ($urandom % 12) == 0;
            tick();
        end
        rst = 1'b0; mov_valido = 1'b0; reiniciar = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_juego.md
# control_juego

Sequencing controller for the TicTacToe board. Owns the 9-cell game matrix, alternates turns between player 1 and player 2, and accepts or rejects moves. After each move it consults the combinational win checker and reports a win, a draw or a turn timeout. It sits between the move-input logic (switches/buttons, already debounced) and the display and win-check logic.

## Interface

- `TIMEOUT_CYCLES`, default 50_000_000 — cycles a player may idle in a turn before the turn passes.
- `clk`  in  1  — system clock.
- `rst`  in  1  — synchronous, active-high reset.
- `mov_valido`  in  1  — single-cycle strobe: the current player submits a move.
- `posicion`  in  4  — target cell 0..8, row-major (0 top-left, 8 bottom-right).
- `reiniciar`  in  1  — single-cycle strobe: start a new game (honoured only in FIN).
- `matrizDeJuego`  out  [8:0][1:0]  — registered board; 00 empty, 01 player 1, 10 player 2.
- `turno`  out  1  — 0 = player 1 to move, 1 = player 2 to move.
- `ganador`  out  2  — 00 none, 01 player 1, 10 player 2; valid in FIN.
- `empate`  out  1  — high in FIN when the board is full with no winner.
- `mov_error`  out  1  — one-cycle pulse when a move is rejected.
- `timeout`  out  1  — one-cycle pulse when a turn expires.
- `juego_activo`  out  1  — high in ESPERA and VERIFICA.

## Operation

**States**
- INICIO: clear board, `turno`=0, timer=0, `ganador`=00, `empate`=0. Always goes to ESPERA the next cycle.
- ESPERA: wait for a move.
  - Accepted move, all three required: `mov_valido`=1, `posicion`≤8, and the target cell is 00.
  - On accept: cell ← player code (01 if `turno`=0, else 10); go to VERIFICA.
  - On `mov_valido` with `posicion`>8 or an occupied cell: pulse `mov_error`; board, turn and timer are unchanged; stay in ESPERA.
- VERIFICA: evaluate the registered board.
  - Win detected: `ganador` ← code of `turno`; go to FIN.
  - Else all 9 cells non-zero: `empate`=1; go to FIN.
  - Else: toggle `turno`, clear timer, return to ESPERA.
- FIN: board frozen; `mov_valido` ignored with no `mov_error`. `reiniciar` → INICIO.

**Timer**
- Counts only in ESPERA; width $clog2(TIMEOUT_CYCLES).
- At count = TIMEOUT_CYCLES-1 with no accepted move that cycle: toggle `turno`, clear timer, pulse `timeout`.
- Accepted move and expiry in the same cycle: the move wins; no timeout.

**Reset and restart**
- `rst` has priority over everything, in any state, including mid-VERIFICA.
- On `rst`: state → INICIO, all outputs 0, board all 00.
- `reiniciar` outside FIN is ignored.

## Timing

- Accepted move at cycle N: board shows the new mark from cycle N+1, while the state is VERIFICA.
- From cycle N+2, one of: FIN with `ganador`/`empate` valid, or ESPERA with `turno` toggled.
- Consequence: at most one accepted move per 2 cycles; `mov_valido` during VERIFICA is ignored.
- `mov_error` and `timeout` are registered pulses, high exactly in cycle N+1.
- `reiniciar` at cycle N: INICIO at N+1, ESPERA at N+2 with a clear board.
- Every output is registered.

## Structure

- Package `tictactoe_pkg`:
  - Cell codes `CELDA_VACIA`=2'b00, `JUGADOR1`=2'b01, `JUGADOR2`=2'b10.
  - State enum `estado_t` {INICIO, ESPERA, VERIFICA, FIN}.
  - Board typedef `tablero_t` = logic [8:0][1:0].
- One sub-module: the existing combinational win checker `always_ganador`, fed with the registered board. Its output is sampled only in VERIFICA.
- Draw detection, timer and FSM live in `control_juego`.

## Test plan

- **Row win:** after reset, moves 0,3,1,4,2 → after the fifth move (cycle N+2): FIN, `ganador`=01, board cells 0,1,2=01 and 3,4=10.
- **Draw:** moves 0,1,2,4,3,5,7,6,8 → FIN, `ganador`=00, `empate`=1, no 00 cells.
- **Illegal move:** occupied cell 0 → `mov_error` pulse, `turno` unchanged. `posicion`=9 → same. Neither move writes the board.
- **Timeout:** TIMEOUT_CYCLES=8, no move for 8 cycles in ESPERA → `timeout` pulse, `turno` 0→1.
- **Move on expiry cycle:** move in the expiry cycle → move accepted, no `timeout` pulse.
- **Reset/restart:**
  - `rst` asserted in VERIFICA → next cycle INICIO, all outputs 0.
  - `reiniciar` in FIN → cleared board and `turno`=0 two cycles later.
  - `reiniciar` in ESPERA → no effect.
